multicycle_sequencer: RTL and testbench

- Multi-cycle control sequencer for the 32-bit processor core.
- Owns the program counter and instruction register.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK, issuing one-cycle enables to the ALU and register file and a req/ack handshake to data memory.
- Sits between the 64-entry instruction memory and the control unit / ALU / data memory datapath.

---
 rtl/multicycle_sequencer_if.sv | 42 ++++
 rtl/multicycle_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_if.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer_if
//   Bus bundle between the multi-cycle sequencer and its datapath neighbours:
//   instruction memory fetch, the instruction register, ALU / register-file
//   strobes and the data-memory req/ack handshake.
//
//   imem_addr  : instruction memory address (sequencer -> imem)
//   imem_rdata : instruction word, one cycle after imem_addr (imem -> sequencer)
//   ir         : instruction register (sequencer -> control unit)
//   alu_en     : one-cycle ALU operate strobe
//   dmem_req   : data memory request, held until dmem_ack
//   dmem_we    : 1 = store, 0 = load, valid while dmem_req
//   dmem_ack   : one-cycle completion pulse (dmem -> sequencer)
//   rf_we      : one-cycle register-file write strobe
//   wb_sel     : writeback mux select, 1 = memory data, 0 = ALU result
//
//   master : the sequencer side.  slave : the datapath / memory side.
// ---------------------------------------------------------------------------
interface multicycle_sequencer_if #(
  parameter int PC_W    = 6,
  parameter int INSTR_W = 32
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] ir;
  logic               alu_en;
  logic               dmem_req;
  logic               dmem_we;
  logic               dmem_ack;
  logic               rf_we;
  logic               wb_sel;

  modport master (
    output imem_addr, ir, alu_en, dmem_req, dmem_we, rf_we, wb_sel,
    input  imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_addr, ir, alu_en, dmem_req, dmem_we, rf_we, wb_sel,
    output imem_rdata, dmem_ack
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
//   Control sequencer for the multi-cycle 32-bit core. Owns the program
//   counter and instruction register and walks every instruction through
//   FETCH -> DECODE -> EXECUTE -> (MEM) -> (WRITEBACK), issuing one-cycle
//   ALU / register-file strobes and a req/ack handshake to data memory.
//
//   Opcode = ir[31:28]: F = HALT, D = LOAD, E = STORE, anything else = ALU.
//
// Ports
//   clk      : rising-edge clock
//   clkreset : asynchronous, active-low reset
//   start    : leaves IDLE; ignored in every other state
//   bus      : multicycle_sequencer_if.master (imem, ir, strobes, dmem)
//   busy     : high in every state except IDLE and HALT
//   halted   : high in HALT (terminal until reset)
//   retired  : saturating count of completed instructions
//   err      : sticky data-memory timeout flag
//
// Build option
//   MEM_TIMEOUT_EN : when defined, a request left unacknowledged for
//                    MEM_TIMEOUT cycles is abandoned, err is set and the
//                    sequencer halts. When undefined, MEM waits forever and
//                    err is constant 0.
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
  parameter int PC_W        = 6,
  parameter int INSTR_W     = 32,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   clkreset,
  input  logic                   start,
  multicycle_sequencer_if.master bus,
  output logic                   busy,
  output logic                   halted,
  output logic [CNT_W-1:0]       retired,
  output logic                   err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'hD;
  localparam logic [3:0] OP_STORE = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [3:0]       ir_op;
  logic [3:0]       rdata_op;
  logic [CNT_W-1:0] retired_inc;

  assign ir_op       = bus.ir[INSTR_W-1 -: 4];
  assign rdata_op    = bus.imem_rdata[INSTR_W-1 -: 4];
  assign bus.imem_addr = pc;

  // Saturate instead of wrapping so software can tell "very many" from "few".
  assign retired_inc = (retired == '1) ? retired : retired + CNT_W'(1);

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  logic [TO_W-1:0] mem_cnt;
`else
  // Constant 0: no timeout hardware exists in this build.
  assign err = (MEM_TIMEOUT < 0);
`endif

  // NOTE: every register here is updated with non-blocking assignments so all
  // of them see the pre-edge values of each other, exactly like real flops.
  always_ff @(posedge clk or negedge clkreset) begin
    if (!clkreset) begin
      state        <= S_IDLE;
      pc           <= '0;
      // NOTE: ir is a plain register, not a memory, so it is reset like any
      // other flop; the control unit then sees a defined word out of reset.
      bus.ir       <= '0;
      bus.alu_en   <= 1'b0;
      bus.dmem_req <= 1'b0;
      bus.dmem_we  <= 1'b0;
      bus.rf_we    <= 1'b0;
      bus.wb_sel   <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      retired      <= '0;
`ifdef MEM_TIMEOUT_EN
      mem_cnt      <= '0;
      err          <= 1'b0;
`endif
    end else begin
      // NOTE: the single-cycle strobes default low every clock; only the
      // transition into the owning state raises them, so they can never
      // stick high for more than one cycle.
      bus.alu_en <= 1'b0;
      bus.rf_we  <= 1'b0;
      bus.wb_sel <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end

        // imem_addr already equals pc; the memory registers the read here.
        S_FETCH: state <= S_DECODE;

        // The fetched word is valid now. Its opcode decides the EXECUTE
        // strobe so alu_en is a registered output aligned with EXECUTE.
        S_DECODE: begin
          bus.ir     <= bus.imem_rdata;
          bus.alu_en <= (rdata_op != OP_HALT);
          state      <= S_EXECUTE;
        end

        S_EXECUTE: begin
          case (ir_op)
            OP_HALT: begin
              state  <= S_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
            OP_LOAD, OP_STORE: begin
              state        <= S_MEM;
              bus.dmem_req <= 1'b1;
              bus.dmem_we  <= (ir_op == OP_STORE);
`ifdef MEM_TIMEOUT_EN
              mem_cnt      <= '0;
`endif
            end
            default: begin
              state     <= S_WRITEBACK;
              bus.rf_we <= 1'b1;
            end
          endcase
        end

        // Request is held until the ack pulse; it drops the cycle after.
        // An ack on the final allowed cycle takes priority over the timeout.
        S_MEM: begin
          if (bus.dmem_ack) begin
            bus.dmem_req <= 1'b0;
            bus.dmem_we  <= 1'b0;
            if (ir_op == OP_STORE) begin
              pc      <= pc + PC_W'(1);
              retired <= retired_inc;
              state   <= S_FETCH;
            end else begin
              bus.rf_we  <= 1'b1;
              bus.wb_sel <= 1'b1;
              state      <= S_WRITEBACK;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (mem_cnt == TO_W'(MEM_TIMEOUT - 1)) begin
            bus.dmem_req <= 1'b0;
            bus.dmem_we  <= 1'b0;
            err          <= 1'b1;
            busy         <= 1'b0;
            halted       <= 1'b1;
            state        <= S_HALT;
          end else begin
            mem_cnt <= mem_cnt + TO_W'(1);
          end
`endif
        end

        // pc wraps naturally at 2**PC_W.
        S_WRITEBACK: begin
          pc      <= pc + PC_W'(1);
          retired <= retired_inc;
          state   <= S_FETCH;
        end

        S_HALT: state <= S_HALT;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer
//   Self-checking bench for multicycle_sequencer. A registered instruction
//   memory model and a data-memory slave with programmable ack delay sit on
//   the interface. Expected strobe events (kind, cycle after start, flag) are
//   pushed into a scoreboard before each run and popped as the DUT raises
//   alu_en / rf_we / a new dmem_req. Cycle 1 is the first cycle after the
//   edge that samples start.
// ---------------------------------------------------------------------------
module tb_multicycle_sequencer;

  localparam int PC_W    = 6;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 16;
  localparam int NO_ACK  = 100000;

  localparam logic [31:0] I_ALU   = 32'h1000_0000;
  localparam logic [31:0] I_ALU2  = 32'hC123_4567;
  localparam logic [31:0] I_LOAD  = 32'hD000_0000;
  localparam logic [31:0] I_STORE = 32'hE000_0000;
  localparam logic [31:0] I_HALT  = 32'hF000_0000;

  localparam int EV_ALU = 0;
  localparam int EV_RF  = 1;
  localparam int EV_REQ = 2;

  typedef struct {
    int   kind;
    int   cyc;
    logic flag;
  } ev_t;

  typedef struct {
    logic [31:0] instr;
    int          dly;
    int          alu_cyc;
    int          req_cyc;
    int          req_len;
    logic        we;
    int          rf_cyc;
    logic        wb_sel;
    int          halt_cyc;
    int          pc_end;
    int          ret_end;
    logic        err_end;
  } vec_t;

  logic             clk = 1'b0;
  logic             clkreset = 1'b0;
  logic             start = 1'b0;
  logic             busy;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] retired;

  multicycle_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  multicycle_sequencer #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W), .MEM_TIMEOUT(15)
  ) dut (
    .clk     (clk),
    .clkreset(clkreset),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .halted  (halted),
    .retired (retired),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Registered-read instruction memory.
  logic [31:0] imem [64];
  always @(posedge clk) bus.imem_rdata <= imem[bus.imem_addr];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   halt_cyc = -1;
  int   req_len = 0;
  int   ack_dly = NO_ACK;
  int   ack_wait = 0;
  logic req_prev = 1'b0;
  logic mon_on = 1'b0;
  logic spur_ack = 1'b0;
  ev_t  sb [$];
  vec_t vecs [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic sb_push(input int kind, input int c, input logic flag);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.flag = flag;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input logic flag);
    ev_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_unexpected: got event kind %0d at cycle %0d expected none", kind, cyc);
    end else begin
      e = sb.pop_front();
      check($sformatf("sb_kind@%0d", cyc), kind, e.kind);
      check($sformatf("sb_cycle(kind%0d)", kind), cyc, e.cyc);
      check($sformatf("sb_flag(kind%0d)@%0d", kind, cyc), flag, e.flag);
    end
  endtask

  // One clock: sample outputs at the falling edge, then drive the dmem slave.
  task automatic tick();
    @(negedge clk);
    if (mon_on) begin
      cyc++;
      if (bus.alu_en) sb_pop(EV_ALU, 1'b0);
      if (bus.rf_we) sb_pop(EV_RF, bus.wb_sel);
      if (bus.dmem_req && !req_prev) sb_pop(EV_REQ, bus.dmem_we);
      if (bus.dmem_req) req_len++;
      check("wb_sel_outside_wb", bus.wb_sel & ~bus.rf_we, 0);
      if (halted && halt_cyc < 0) halt_cyc = cyc;
    end
    req_prev = bus.dmem_req;
    if (bus.dmem_req) begin
      bus.dmem_ack = (ack_wait == ack_dly) | spur_ack;
      ack_wait++;
    end else begin
      bus.dmem_ack = spur_ack;
      ack_wait = 0;
    end
  endtask

  task automatic do_reset();
    mon_on   = 1'b0;
    start    = 1'b0;
    spur_ack = 1'b0;
    ack_dly  = NO_ACK;
    #2 clkreset = 1'b0;
    #1;
    check("rst_imem_addr", bus.imem_addr, 0);
    check("rst_ir",        bus.ir, 0);
    check("rst_alu_en",    bus.alu_en, 0);
    check("rst_rf_we",     bus.rf_we, 0);
    check("rst_wb_sel",    bus.wb_sel, 0);
    check("rst_dmem_req",  bus.dmem_req, 0);
    check("rst_dmem_we",   bus.dmem_we, 0);
    check("rst_busy",      busy, 0);
    check("rst_halted",    halted, 0);
    check("rst_retired",   retired, 0);
    check("rst_err",       err, 0);
    tick();
    tick();
    clkreset = 1'b1;
    tick();
  endtask

  // Called just after a falling edge: start is sampled at the next rising edge.
  task automatic start_run(input logic hold);
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc      = 0;
    halt_cyc = -1;
    req_len  = 0;
    mon_on   = 1'b1;
    start    = hold;
  endtask

  task automatic wait_halt(input int max_cyc);
    for (int i = 0; i < max_cyc && halt_cyc < 0; i++) tick();
  endtask

  task automatic fill_halt();
    for (int a = 0; a < 64; a++) imem[a] = I_HALT;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    bus.dmem_ack = 1'b0;
    fill_halt();

    // instr, dly, alu, req, len, we, rf, wb_sel, halt, pc, retired, err
    vecs.push_back(vec_t'{I_ALU,   0,      3, -1,  0, 1'b0,  4, 1'b0,  8, 1, 1, 1'b0});
    vecs.push_back(vec_t'{I_ALU2,  0,      3, -1,  0, 1'b0,  4, 1'b0,  8, 1, 1, 1'b0});
    vecs.push_back(vec_t'{I_LOAD,  0,      3,  4,  1, 1'b0,  5, 1'b1,  9, 1, 1, 1'b0});
    vecs.push_back(vec_t'{I_LOAD,  2,      3,  4,  3, 1'b0,  7, 1'b1, 11, 1, 1, 1'b0});
    vecs.push_back(vec_t'{I_LOAD,  14,     3,  4, 15, 1'b0, 19, 1'b1, 23, 1, 1, 1'b0});
    vecs.push_back(vec_t'{I_STORE, 0,      3,  4,  1, 1'b1, -1, 1'b0,  8, 1, 1, 1'b0});
    vecs.push_back(vec_t'{I_STORE, 4,      3,  4,  5, 1'b1, -1, 1'b0, 12, 1, 1, 1'b0});
    vecs.push_back(vec_t'{I_HALT,  0,     -1, -1,  0, 1'b0, -1, 1'b0,  4, 0, 0, 1'b0});
`ifdef MEM_TIMEOUT_EN
    vecs.push_back(vec_t'{I_LOAD,  NO_ACK, 3,  4, 15, 1'b0, -1, 1'b0, 19, 0, 0, 1'b1});
`endif

    // ---- table: one instruction at address 0, HALT behind it ----
    foreach (vecs[i]) begin
      v = vecs[i];
      do_reset();
      fill_halt();
      imem[0] = v.instr;
      ack_dly = v.dly;
      if (v.alu_cyc >= 0) sb_push(EV_ALU, v.alu_cyc, 1'b0);
      if (v.req_cyc >= 0) sb_push(EV_REQ, v.req_cyc, v.we);
      if (v.rf_cyc >= 0)  sb_push(EV_RF, v.rf_cyc, v.wb_sel);
      start_run(1'b0);
      wait_halt(100);
      tick();
      tick();
      check($sformatf("row%0d_halt_cycle", i), halt_cyc, v.halt_cyc);
      check($sformatf("row%0d_req_len", i), req_len, v.req_len);
      check($sformatf("row%0d_pc", i), bus.imem_addr, v.pc_end);
      check($sformatf("row%0d_retired", i), retired, v.ret_end);
      check($sformatf("row%0d_busy", i), busy, 0);
      check($sformatf("row%0d_dmem_req", i), bus.dmem_req, 0);
      check($sformatf("row%0d_err", i), err, v.err_end);
      check($sformatf("row%0d_sb_drained", i), sb.size(), 0);
      sb.delete();
    end

    // ---- three ALU ops, start held high, stray ack outside MEM ----
    do_reset();
    fill_halt();
    for (int a = 0; a < 3; a++) imem[a] = I_ALU;
    for (int k = 0; k < 3; k++) begin
      sb_push(EV_ALU, 3 + 4 * k, 1'b0);
      sb_push(EV_RF,  4 + 4 * k, 1'b0);
    end
    start_run(1'b1);
    repeat (4) tick();
    spur_ack = 1'b1;
    tick();
    spur_ack = 1'b0;
    wait_halt(100);
    check("alu3_halt_cycle", halt_cyc, 16);
    check("alu3_pc", bus.imem_addr, 3);
    check("alu3_retired", retired, 3);
    check("alu3_busy_in_halt", busy, 0);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("halt_ignores_start_halted", halted, 1);
    check("halt_ignores_start_busy", busy, 0);
    check("halt_ignores_start_retired", retired, 3);
    check("alu3_sb_drained", sb.size(), 0);
    sb.delete();

    // ---- pc wrap: 64 ALU ops, then HALT placed at address 0 ----
    do_reset();
    for (int a = 0; a < 64; a++) imem[a] = I_ALU;
    for (int k = 0; k < 64; k++) begin
      sb_push(EV_ALU, 3 + 4 * k, 1'b0);
      sb_push(EV_RF,  4 + 4 * k, 1'b0);
    end
    start_run(1'b0);
    for (int i = 0; i < 400 && retired != 16'd64; i++) tick();
    check("wrap_retired", retired, 64);
    check("wrap_pc", bus.imem_addr, 0);
    check("wrap_cycle", cyc, 257);
    imem[0] = I_HALT;
    wait_halt(50);
    check("wrap_halt_cycle", halt_cyc, 260);
    check("wrap_halted", halted, 1);
    check("wrap_busy", busy, 0);
    check("wrap_retired_final", retired, 64);
    check("wrap_sb_drained", sb.size(), 0);
    sb.delete();

    // ---- reset while waiting in MEM ----
    do_reset();
    fill_halt();
    imem[0] = I_ALU;
    imem[1] = I_LOAD;
    sb_push(EV_ALU, 3, 1'b0);
    sb_push(EV_RF,  4, 1'b0);
    sb_push(EV_ALU, 7, 1'b0);
    sb_push(EV_REQ, 8, 1'b0);
    start_run(1'b0);
    repeat (10) tick();
    check("memwait_dmem_req", bus.dmem_req, 1);
    check("memwait_busy", busy, 1);
    check("memwait_retired", retired, 1);
    check("memwait_pc", bus.imem_addr, 1);
    check("memwait_sb_drained", sb.size(), 0);
    sb.delete();
    do_reset();
    repeat (8) tick();
    check("post_reset_idle_busy", busy, 0);
    check("post_reset_idle_pc", bus.imem_addr, 0);
    check("post_reset_idle_req", bus.dmem_req, 0);
    check("post_reset_idle_retired", retired, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
